// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown timer block.
package countdown_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_PRE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/countdown_core.sv
// Loadable down counter that stops at zero and never wraps.
module countdown_core
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  // Load has priority over decrement; zero holds instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && !zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer: control FSM, prescaler and capture registers around a
// loadable down counter.
module countdown_timer_ctrl
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PRE_W-1:0] prescale,
  input  logic             auto_reload,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done
);

  state_t           state;
  logic [PRE_W-1:0] pre_cnt;
  logic [WIDTH-1:0] cap_load;
  logic [PRE_W-1:0] cap_pre;
  logic             cap_auto;

  logic             active;
  logic             advance;
  logic             tick;
  logic             accept;
  logic             zero;
  logic             core_load;
  logic [WIDTH-1:0] core_value;

  // Pause is a level freeze: the prescaler advances only while pause is low,
  // so the PAUSED state reports the freeze and the cycle that leaves it can
  // already count. Abort overrides everything, so no tick in an abort cycle.
  assign active   = (state == RUN) || (state == PAUSED);
  assign advance  = active && !pause && !abort;
  assign tick     = advance && (pre_cnt == cap_pre);
  assign tc_pulse = tick && zero;
  assign accept   = ((state == IDLE) || (state == DONE)) && start && !abort;

  // The counter is (re)loaded on abort (to zero), on an accepted start, and on
  // a terminal count when auto-reload was captured.
  assign core_load  = abort || accept || (tc_pulse && cap_auto);
  assign core_value = abort ? '0 : (accept ? load_val : cap_load);

  countdown_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (core_load),
    .load_value(core_value),
    .enable    (tick),
    .count     (count),
    .zero      (zero)
  );

  // Control FSM with prescaler, capture registers and registered busy/done.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every register in this block is reset, including the captured
    // configuration, so nothing stale survives a mid-operation reset.
    if (!reset) begin
      state    <= IDLE;
      pre_cnt  <= '0;
      cap_load <= '0;
      cap_pre  <= '0;
      cap_auto <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      pre_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            cap_load <= load_val;
            cap_pre  <= prescale;
            cap_auto <= auto_reload;
            pre_cnt  <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        RUN, PAUSED: begin
          if (pause) begin
            state <= PAUSED;
          end else begin
            state <= RUN;
            if (tick) begin
              pre_cnt <= '0;
              if (zero && !cap_auto) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Scoreboard bench for countdown_timer_ctrl: the stimulus process queues the
// expected per-cycle outputs from an arithmetic reference model; a monitor
// pops and compares on every falling edge.
module tb_countdown_timer_ctrl;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [PW-1:0] prescale = '0;
  logic          auto_reload = 1'b0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  count;
  logic          busy;
  logic          tc_pulse;
  logic          done;

  countdown_timer_ctrl #(.WIDTH(W), .PRE_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_val   (load_val),
    .prescale   (prescale),
    .auto_reload(auto_reload),
    .pause      (pause),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .tc_pulse   (tc_pulse),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int count;
    bit busy;
    bit done;
    bit tc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   tc_seen = 0;

  // Reference model: mode 0=idle, 1=counting (running or paused), 2=done.
  // m_n counts unpaused counting cycles since the last (re)load.
  int m_mode = 0;
  int m_l = 0;
  int m_p = 0;
  bit m_a = 1'b0;
  int m_n = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock cycle of stimulus; records what the outputs must be this cycle.
  task automatic step(input bit s, input int l, input int p, input bit ar,
                      input bit pa, input bit ab);
    exp_t e;
    int   period;
    @(posedge clk);
    #1;
    start       = s;
    load_val    = W'(l);
    prescale    = PW'(p);
    auto_reload = ar;
    pause       = pa;
    abort       = ab;
    period  = (m_l + 1) * (m_p + 1);
    e.count = (m_mode == 1) ? (m_l - m_n / (m_p + 1)) : 0;
    e.busy  = (m_mode == 1);
    e.done  = (m_mode == 2);
    e.tc    = (m_mode == 1) && !pa && !ab && (m_n == period - 1);
    exp_q.push_back(e);
    if (ab) begin
      m_mode = 0;
    end else if (m_mode != 1) begin
      if (s) begin
        m_mode = 1;
        m_l = l;
        m_p = p;
        m_a = ar;
        m_n = 0;
      end
    end else if (!pa) begin
      if (m_n == period - 1) begin
        m_n = 0;
        if (!m_a) m_mode = 2;
      end else begin
        m_n++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset mid-cycle, confirm outputs clear at once, then release.
  task automatic do_reset(input int hold);
    exp_t e;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tc", int'(tc_pulse), 0);
    m_mode = 0;
    repeat (hold) @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    e.count = 0;
    e.busy  = 1'b0;
    e.done  = 1'b0;
    e.tc    = 1'b0;
    exp_q.push_back(e);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (exp_q.size() == 0) begin
          failures++;
          checks++;
          $display("FAIL queue_underflow: got 0 entries expected 1 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("count", int'(count), e.count);
          check("busy", int'(busy), int'(e.busy));
          check("done", int'(done), int'(e.done));
          check("tc_pulse", int'(tc_pulse), int'(e.tc));
          if (tc_pulse) tc_seen++;
        end
      end
    end
  end

  initial begin
    do_reset(2);
    // Start on the very first edge after release.
    step(1, 3, 0, 0, 0, 0);
    idle(6);
    // Auto-reload, then abort.
    step(1, 2, 2, 1, 0, 0);
    idle(30);
    step(0, 0, 0, 0, 0, 1);
    idle(3);
    // Pause for 7 cycles once the count reaches 3.
    step(1, 5, 1, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 0);
    idle(12);
    // Zero load.
    step(1, 0, 0, 0, 0, 0);
    idle(3);
    // Start while busy, then abort+start in idle.
    step(1, 4, 3, 0, 0, 0);
    idle(3);
    step(1, 10, 0, 1, 0, 0);
    idle(22);
    step(0, 0, 0, 0, 0, 1);
    step(1, 10, 0, 0, 0, 1);
    idle(2);
    // Reset at count=4, then a fresh short run.
    step(1, 6, 0, 0, 0, 0);
    idle(2);
    do_reset(1);
    step(1, 1, 0, 0, 0, 0);
    idle(4);
    // Randomized traffic with config inputs toggling while busy.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) begin
        do_reset($urandom_range(0, 2));
      end else begin
        step(($urandom_range(0, 3) == 0),
             ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12)),
             int'($urandom_range(0, 15)),
             ($urandom_range(0, 1) == 1),
             ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 149) == 0));
      end
    end
    idle(1);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    if (tc_seen == 0) begin
      failures++;
      $display("FAIL tc_activity: got %0d pulses expected more than 0", tc_seen);
    end
    checks++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
